mem_access_ctrl: RTL

//  Sequences a single outstanding load/store between the CPU MEM stage and the data memory.
//  - Generates byte enables and store-data lane replication.
//  - Aligns load data to bit 0 and drives the load extender (ext_ctrl/ext_sign), then returns its result.
//  - Handles memory wait states with an ack handshake, a timeout, and misaligned-access policy.

---
 rtl/mem_access_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store sequencer between the CPU MEM stage and data memory.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning them.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] ext_data,
    output logic [2:0]  ext_ctrl,
    output logic        ext_sign,
    input  logic [31:0] ext_result
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    localparam logic [2:0] T_WORD   = 3'b000;
    localparam logic [2:0] T_HALF_S = 3'b001;
    localparam logic [2:0] T_BYTE_S = 3'b010;
    localparam logic [2:0] T_BYTE_U = 3'b011;
    localparam logic [2:0] T_HALF_U = 3'b100;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_we;
    logic              r_err;
    logic [31:0]       r_addr;
    logic [3:0]        r_we_lanes;
    logic [31:0]       r_wdata;
    logic [31:0]       r_ext_data;
    logic [2:0]        r_ext_ctrl;
    logic              r_ext_sign;
    logic [TO_W-1:0]   r_cnt;

    logic              w_accept;
    logic              w_trap;
    logic              w_is_byte;
    logic              w_is_half;
    logic [2:0]        w_type;
    logic [1:0]        w_lane;
    logic [3:0]        w_we_lanes;
    logic [31:0]       w_wdata_rep;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // Request decode: normalise the type, pick the effective lane, build enables and replicated data.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        w_type      = (req_type > T_HALF_U) ? T_WORD : req_type;
        w_is_byte   = (w_type == T_BYTE_S) || (w_type == T_BYTE_U);
        w_is_half   = (w_type == T_HALF_S) || (w_type == T_HALF_U);
        w_lane      = req_addr[1:0];
        w_we_lanes  = 4'b1111;
        w_wdata_rep = req_wdata;
        if (w_is_byte) begin
            w_we_lanes  = 4'b0001 << w_lane;
            w_wdata_rep = {4{req_wdata[7:0]}};
        end else if (w_is_half) begin
            w_lane[0]   = 1'b0;
            w_we_lanes  = 4'b0011 << w_lane;
            w_wdata_rep = {2{req_wdata[15:0]}};
        end else begin
            w_lane      = 2'b00;
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign w_trap = w_is_half ? req_addr[0] : (!w_is_byte && (req_addr[1:0] != 2'b00));
`else
    assign w_trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = w_trap ? S_RESP : S_BUS;
            S_BUS:  if (mem_ack || (r_cnt == TO_LAST)) w_next_state = S_RESP;
            S_RESP: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_we_lanes <= '0;
            r_wdata    <= '0;
            r_ext_data <= '0;
            r_ext_ctrl <= '0;
            r_ext_sign <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we       <= req_we;
                        r_addr     <= {req_addr[31:2], w_lane};
                        r_we_lanes <= req_we ? w_we_lanes : 4'b0000;
                        r_wdata    <= w_wdata_rep;
                        r_ext_ctrl <= w_type;
                        r_ext_sign <= (w_type == T_HALF_S) || (w_type == T_BYTE_S);
                        r_err      <= w_trap;
                        r_cnt      <= '0;
                    end
                end
                S_BUS: begin
                    r_cnt <= r_cnt + 1'b1;
                    // An ack in the final timeout cycle still counts as success.
                    if (mem_ack) begin
                        r_err <= 1'b0;
                        if (!r_we) r_ext_data <= mem_rdata >> {r_addr[1:0], 3'b000};
                    end else if (r_cnt == TO_LAST) begin
                        r_err <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_cnt      <= '0;
                    r_err      <= 1'b0;
                    r_ext_data <= '0;
                    r_ext_ctrl <= '0;
                    r_ext_sign <= 1'b0;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign mem_en    = (r_state == S_BUS);
    assign mem_we    = mem_en ? r_we_lanes : 4'b0000;
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_wdata = r_wdata;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_rdata = (rsp_valid && !r_we && !r_err) ? ext_result : 32'h0;
    assign ext_data  = r_ext_data;
    assign ext_ctrl  = r_ext_ctrl;
    assign ext_sign  = r_ext_sign;

endmodule
